// File: rtl/multi_port_fifo_pkg.sv
// Shared sizing helpers for the multi-port FIFO and its pointer adder.
package fifo_pkg;

  // Width needed to hold an occupancy value in 0..depth.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a ring index in 0..depth-1 (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/multi_port_fifo_ring_ptr_add.sv
// Combinational (ptr + inc) mod DEPTH for inc <= DEPTH, valid for any DEPTH.
module ring_ptr_add
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = ptr_w(DEPTH),
  parameter int unsigned IW    = cnt_w(DEPTH)
) (
  input  logic [PW-1:0] i_ptr,
  input  logic [IW-1:0] i_inc,
  output logic [PW-1:0] o_sum
);

  // One spare bit holds ptr+inc (at most 2*DEPTH-1) before the wrap.
  localparam int unsigned SW = PW + 1;

  logic [SW-1:0] w_sum;

  // Add, then subtract DEPTH once if the sum ran past the end of the ring.
  always_comb begin
    w_sum = SW'(i_ptr) + SW'(i_inc);
    if (w_sum >= SW'(DEPTH)) begin
      o_sum = PW'(w_sum - SW'(DEPTH));
    end else begin
      o_sum = PW'(w_sum);
    end
  end

endmodule

// File: rtl/multi_port_fifo.sv
// Multi-port circular FIFO with first-word-fall-through reads and sync flush.
module multi_port_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned WR_PORTS     = 2,
  parameter int unsigned RD_PORTS     = 2,
  parameter int unsigned AFULL_THRESH = DEPTH - WR_PORTS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data,
  output logic [WR_PORTS-1:0]            wr_ready,
  input  logic [RD_PORTS-1:0]            rd_en,
  output logic [RD_PORTS-1:0]            rd_valid,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [cnt_w(DEPTH)-1:0]        count,
  output logic [cnt_w(DEPTH)-1:0]        free,
  output logic                           empty,
  output logic                           full,
  output logic                           almost_full
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;

  logic [CW-1:0]         w_free;
  logic [WR_PORTS-1:0]   w_wr_acc;
  logic [RD_PORTS-1:0]   w_rd_acc;
  logic [CW-1:0]         w_n_wr;
  logic [CW-1:0]         w_n_rd;
  logic [PW-1:0]         w_wr_ptr_nxt;
  logic [PW-1:0]         w_rd_ptr_nxt;
  logic [PW-1:0]         w_wr_slot [WR_PORTS];
  logic [PW-1:0]         w_rd_slot [RD_PORTS];
  logic [CW:0]           w_cnt_sum;
  logic [CW-1:0]         w_cnt_nxt;

  assign w_free = CW'(DEPTH) - r_count;

  // Write lanes: readiness from registered free space only, slot = wr_ptr+i.
  for (genvar gi = 0; gi < WR_PORTS; gi++) begin : g_wr
    assign wr_ready[gi] = (w_free > CW'(gi));
    assign w_wr_acc[gi] = wr_en[gi] & wr_ready[gi];
    ring_ptr_add #(.DEPTH(DEPTH), .PW(PW), .IW(CW)) u_wr_slot (
      .i_ptr (r_wr_ptr),
      .i_inc (CW'(gi)),
      .o_sum (w_wr_slot[gi])
    );
  end

  // Read lanes: FWFT view of head+i, zeroed when the lane holds nothing.
  for (genvar gr = 0; gr < RD_PORTS; gr++) begin : g_rd
    assign rd_valid[gr] = (r_count > CW'(gr));
    assign w_rd_acc[gr] = rd_en[gr] & rd_valid[gr];
    ring_ptr_add #(.DEPTH(DEPTH), .PW(PW), .IW(CW)) u_rd_slot (
      .i_ptr (r_rd_ptr),
      .i_inc (CW'(gr)),
      .o_sum (w_rd_slot[gr])
    );
    assign rd_data[gr*DATA_WIDTH +: DATA_WIDTH] =
      rd_valid[gr] ? r_mem[w_rd_slot[gr]] : '0;
  end

  // Number of lanes accepted this cycle on each side.
  always_comb begin
    w_n_wr = '0;
    w_n_rd = '0;
    for (int unsigned i = 0; i < WR_PORTS; i++) begin
      w_n_wr = w_n_wr + CW'(w_wr_acc[i]);
    end
    for (int unsigned i = 0; i < RD_PORTS; i++) begin
      w_n_rd = w_n_rd + CW'(w_rd_acc[i]);
    end
  end

  ring_ptr_add #(.DEPTH(DEPTH), .PW(PW), .IW(CW)) u_wr_adv (
    .i_ptr (r_wr_ptr),
    .i_inc (w_n_wr),
    .o_sum (w_wr_ptr_nxt)
  );

  ring_ptr_add #(.DEPTH(DEPTH), .PW(PW), .IW(CW)) u_rd_adv (
    .i_ptr (r_rd_ptr),
    .i_inc (w_n_rd),
    .o_sum (w_rd_ptr_nxt)
  );

  // Next occupancy at one extra bit, held inside 0..DEPTH.
  always_comb begin
    w_cnt_sum = (CW+1)'(r_count) + (CW+1)'(w_n_wr) - (CW+1)'(w_n_rd);
    // Top bit set can only mean the subtraction went below zero.
    if (w_cnt_sum[CW]) begin
      w_cnt_nxt = '0;
    end else if (w_cnt_sum[CW-1:0] > CW'(DEPTH)) begin
      w_cnt_nxt = CW'(DEPTH);
    end else begin
      w_cnt_nxt = w_cnt_sum[CW-1:0];
    end
  end

  // Pointer and occupancy state; flush discards any same-cycle traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_cnt_nxt;
    end
  end

  // Ring storage: accepted lanes land at wr_ptr+i; contents are not reset.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int unsigned i = 0; i < WR_PORTS; i++) begin
        if (w_wr_acc[i]) begin
          r_mem[w_wr_slot[i]] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign count       = r_count;
  assign free        = w_free;
  assign empty       = (r_count == '0);
  assign full        = (r_count == CW'(DEPTH));
  assign almost_full = (r_count >= CW'(AFULL_THRESH));

endmodule
